// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: N-digit multiplexed 7-segment scanner with per-frame input snapshot, blank gap and blink cursor; `SEG_SCAN_LZB_EN adds leading-zero blanking.
// Outputs registered, one cycle behind the scan counters (sec_p reaches the display in 3-4 cycles); free-running, no flow control.
module seg_scan_ctrl #(
  parameter int N_DIGITS = 8,
  parameter int DWELL    = 1000,
  parameter int BLANK    = 2
) (
  input  logic                  mclk,
  input  logic                  rst_n,
  input  logic [4*N_DIGITS-1:0] digits,
  input  logic [N_DIGITS-1:0]   dp,
  input  logic [N_DIGITS-1:0]   blink_mask,
  input  logic                  sec_p,
  output logic [N_DIGITS-1:0]   seg_sel,
  output logic [7:0]            seg_db,
  output logic                  frame_p
);

  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

  logic [CW-1:0]         cnt;
  logic [IW-1:0]         idx;
  logic [4*N_DIGITS-1:0] sh_dig;
  logic [N_DIGITS-1:0]   sh_dp;
  logic [N_DIGITS-1:0]   sh_blink;
  logic                  started;
  logic                  phase;
  logic [2:0]            sec_sync;
  logic                  slot_end;
  logic                  frame_end;
  logic [3:0]            cur_dig;
  logic [6:0]            cur_seg;
  logic [7:0]            db_nxt;
  logic [N_DIGITS-1:0]   lzb;

  assign slot_end  = (cnt == CW'(DWELL - 1));
  assign frame_end = slot_end && (idx == IW'(N_DIGITS - 1));
  assign cur_dig   = sh_dig[{idx, 2'b00} +: 4];

  always_comb begin
    case (cur_dig)
      4'd0:    cur_seg = 7'h3F;
      4'd1:    cur_seg = 7'h06;
      4'd2:    cur_seg = 7'h5B;
      4'd3:    cur_seg = 7'h4F;
      4'd4:    cur_seg = 7'h66;
      4'd5:    cur_seg = 7'h6D;
      4'd6:    cur_seg = 7'h7D;
      4'd7:    cur_seg = 7'h27;
      4'd8:    cur_seg = 7'h7F;
      4'd9:    cur_seg = 7'h6F;
      default: cur_seg = 7'h00;
    endcase
  end

`ifdef SEG_SCAN_LZB_EN
  logic lz_run;

  // Walk down from the most significant digit; the run stops at the first non-blank candidate.
  always_comb begin
    lzb    = '0;
    lz_run = 1'b1;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      lz_run = lz_run && (sh_dig[4*i +: 4] == 4'd0) && !sh_dp[i];
      lzb[i] = lz_run;
    end
  end
`else
  assign lzb = '0;
`endif

  always_comb begin
    db_nxt = {sh_dp[idx], cur_seg};
    if (sh_blink[idx] && phase) begin
      db_nxt = 8'h08;
    end else if (lzb[idx]) begin
      db_nxt = 8'h00;
    end
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      idx      <= '0;
      sh_dig   <= '0;
      sh_dp    <= '0;
      sh_blink <= '0;
      started  <= 1'b0;
      phase    <= 1'b0;
      sec_sync <= '0;
      seg_sel  <= '1;
      seg_db   <= '0;
      frame_p  <= 1'b0;
    end else begin
      sec_sync <= {sec_sync[1:0], sec_p};
      if (sec_sync[1] && !sec_sync[2]) begin
        phase <= ~phase;
      end

      cnt <= slot_end ? '0 : cnt + CW'(1);
      if (slot_end) begin
        idx <= (idx == IW'(N_DIGITS - 1)) ? '0 : idx + IW'(1);
      end

      // Shadow copy is taken on the first edge and then only at the frame wrap.
      started <= 1'b1;
      if (!started || frame_end) begin
        sh_dig   <= digits;
        sh_dp    <= dp;
        sh_blink <= blink_mask;
      end

      frame_p <= frame_end;
      if (cnt < CW'(BLANK)) begin
        seg_sel <= '1;
        seg_db  <= '0;
      end else begin
        seg_sel <= ~(N_DIGITS'(1) << idx);
        seg_db  <= db_nxt;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (N_DIGITS=4, DWELL=4, BLANK=1); build with +define+SEG_SCAN_LZB_EN to cover blanking.
module tb_seg_scan_ctrl;

  localparam int ND = 4;
  localparam int DW = 4;
  localparam int BL = 1;
  localparam int FR = ND * DW;
  localparam logic [6:0] SEG7 [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h27,
                                       7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};

  typedef struct {
    logic [ND-1:0] sel;
    logic [7:0]    db;
    logic          fp;
  } exp_t;

  logic          mclk;
  logic          rst_n;
  logic [4*ND-1:0] digits;
  logic [ND-1:0] dp;
  logic [ND-1:0] blink_mask;
  logic          sec_p;
  logic [ND-1:0] seg_sel;
  logic [7:0]    seg_db;
  logic          frame_p;

  exp_t          sb[$];
  int            pos;
  logic [4*ND-1:0] s_dig;
  logic [ND-1:0] s_dp;
  logic [ND-1:0] s_bm;
  logic          ph;
  int            errors;
  int            checks;

  seg_scan_ctrl #(.N_DIGITS(ND), .DWELL(DW), .BLANK(BL)) dut (
    .mclk       (mclk),
    .rst_n      (rst_n),
    .digits     (digits),
    .dp         (dp),
    .blink_mask (blink_mask),
    .sec_p      (sec_p),
    .seg_sel    (seg_sel),
    .seg_db     (seg_db),
    .frame_p    (frame_p)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Expected outputs for frame position p, from the bench's snapshot copy and blink phase.
  function automatic exp_t model(int p);
    exp_t e;
    int   slot;
    int   k;
    logic lz;
    slot = p / DW;
    k    = p % DW;
    e.fp = (p == FR - 1);
    if (k < BL) begin
      e.sel = '1;
      e.db  = 8'h00;
    end else begin
      e.sel = ~(ND'(1) << slot);
      if (s_bm[slot] && ph) e.db = 8'h08;
      else e.db = {s_dp[slot], SEG7[s_dig[4*slot +: 4]]};
`ifdef SEG_SCAN_LZB_EN
      lz = (slot != 0);
      for (int j = slot; j < ND; j++) begin
        if (s_dig[4*j +: 4] != 4'd0 || s_dp[j]) lz = 1'b0;
      end
      if (lz && !(s_bm[slot] && ph)) e.db = 8'h00;
`endif
    end
    return e;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge mclk);
    @(negedge mclk);
    rst_n = 1'b1;
    pos   = 0;
    ph    = 1'b0;
    s_dig = digits;
    s_dp  = dp;
    s_bm  = blink_mask;
    sb.delete();
  endtask

  task automatic tick();
    sb.push_back(model(pos));
    @(posedge mclk);
    #1;
  endtask

  task automatic adv();
    if (pos == FR - 1) begin
      s_dig = digits;
      s_dp  = dp;
      s_bm  = blink_mask;
    end
    pos = (pos + 1) % FR;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (seg_sel !== 4'hF) begin errors++; $display("FAIL reset_sel got=%b want=1111", seg_sel); end
    checks++;
    if (seg_db !== 8'h00) begin errors++; $display("FAIL reset_db got=%h want=00", seg_db); end
    checks++;
    if (frame_p !== 1'b0) begin errors++; $display("FAIL reset_fp got=%b want=0", frame_p); end
  endtask

  task automatic test_scan();
    exp_t e;
    logic [7:0] want;
    digits = 16'h1234; dp = '0; blink_mask = '0;
    do_reset();
    for (int c = 0; c < FR; c++) begin
      tick(); e = sb.pop_front(); checks++;
      if (seg_sel !== e.sel || seg_db !== e.db || frame_p !== e.fp) begin
        errors++;
        $display("FAIL scan cyc=%0d got sel=%b db=%h fp=%b want sel=%b db=%h fp=%b", c, seg_sel, seg_db, frame_p, e.sel, e.db, e.fp);
      end
      if (c == 1 || c == 5 || c == 9 || c == 13) begin
        want = (c == 1) ? 8'h66 : (c == 5) ? 8'h4F : (c == 9) ? 8'h5B : 8'h06;
        checks++;
        if (seg_db !== want) begin errors++; $display("FAIL scan_digit cyc=%0d got=%h want=%h", c, seg_db, want); end
      end
      adv();
    end
  endtask

  task automatic test_snapshot();
    exp_t e;
    logic [7:0] want;
    digits = 16'h1234; dp = '0; blink_mask = '0;
    do_reset();
    for (int c = 0; c < 2 * FR; c++) begin
      tick(); e = sb.pop_front(); checks++;
      if (seg_sel !== e.sel || seg_db !== e.db || frame_p !== e.fp) begin
        errors++;
        $display("FAIL snapshot cyc=%0d got sel=%b db=%h fp=%b want sel=%b db=%h fp=%b", c, seg_sel, seg_db, frame_p, e.sel, e.db, e.fp);
      end
      if (c == 9 || c == 13 || c == 17 || c == 29) begin
        want = (c == 9) ? 8'h5B : (c == 13) ? 8'h06 : 8'h6F;
        checks++;
        if (seg_db !== want) begin errors++; $display("FAIL snapshot_digit cyc=%0d got=%h want=%h", c, seg_db, want); end
      end
      adv();
      if (c == 6) digits = 16'h9999;
    end
  endtask

  task automatic test_blink();
    exp_t e;
    logic [7:0] want;
    digits = 16'h1234; dp = '0; blink_mask = 4'b0001; sec_p = 1'b0;
    do_reset();
    for (int c = 0; c < 4 * FR; c++) begin
      tick(); e = sb.pop_front();
      // Phase change lands somewhere in these windows; exact cycle is checked right after.
      if (!((c >= 16 && c <= 18) || (c >= 48 && c <= 50))) begin
        checks++;
        if (seg_sel !== e.sel || seg_db !== e.db || frame_p !== e.fp) begin
          errors++;
          $display("FAIL blink cyc=%0d got sel=%b db=%h fp=%b want sel=%b db=%h fp=%b", c, seg_sel, seg_db, frame_p, e.sel, e.db, e.fp);
        end
      end
      if (c == 19 || c == 33 || c == 37 || c == 51) begin
        want = (c == 37) ? 8'h4F : (c == 51) ? 8'h66 : 8'h08;
        checks++;
        if (seg_db !== want) begin errors++; $display("FAIL blink_digit cyc=%0d got=%h want=%h", c, seg_db, want); end
      end
      adv();
      if (c == 15 || c == 47) sec_p = 1'b1;
      if (c == 17 || c == 49) sec_p = 1'b0;
      if (c == 18) ph = 1'b1;
      if (c == 50) ph = 1'b0;
    end
    blink_mask = '0;
  endtask

  task automatic test_invalid_dp();
    exp_t e;
    digits = 16'h123C; dp = 4'b0001; blink_mask = '0;
    do_reset();
    for (int c = 0; c < FR; c++) begin
      tick(); e = sb.pop_front(); checks++;
      if (seg_sel !== e.sel || seg_db !== e.db || frame_p !== e.fp) begin
        errors++;
        $display("FAIL invalid_dp cyc=%0d got sel=%b db=%h fp=%b want sel=%b db=%h fp=%b", c, seg_sel, seg_db, frame_p, e.sel, e.db, e.fp);
      end
      if (c == 2) begin
        checks++;
        if (seg_db !== 8'h80) begin errors++; $display("FAIL invalid_dp_digit got=%h want=80", seg_db); end
      end
      adv();
    end
    dp = '0;
  endtask

  task automatic test_midframe_reset();
    exp_t e;
    digits = 16'h1234; dp = '0; blink_mask = '0;
    do_reset();
    for (int c = 0; c <= 10; c++) begin
      tick(); e = sb.pop_front(); checks++;
      if (seg_sel !== e.sel || seg_db !== e.db || frame_p !== e.fp) begin
        errors++;
        $display("FAIL pre_reset cyc=%0d got sel=%b db=%h fp=%b want sel=%b db=%h fp=%b", c, seg_sel, seg_db, frame_p, e.sel, e.db, e.fp);
      end
      adv();
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (seg_sel !== 4'hF || seg_db !== 8'h00 || frame_p !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got sel=%b db=%h fp=%b want sel=1111 db=00 fp=0", seg_sel, seg_db, frame_p);
    end
    do_reset();
    for (int c = 0; c < 8; c++) begin
      tick(); e = sb.pop_front(); checks++;
      if (seg_sel !== e.sel || seg_db !== e.db || frame_p !== e.fp) begin
        errors++;
        $display("FAIL post_reset cyc=%0d got sel=%b db=%h fp=%b want sel=%b db=%h fp=%b", c, seg_sel, seg_db, frame_p, e.sel, e.db, e.fp);
      end
      if (c == 1) begin
        checks++;
        if (seg_sel !== 4'b1110 || seg_db !== 8'h66) begin
          errors++; $display("FAIL restart got sel=%b db=%h want sel=1110 db=66", seg_sel, seg_db);
        end
      end
      adv();
    end
  endtask

`ifdef SEG_SCAN_LZB_EN
  task automatic test_lzb();
    exp_t e;
    logic [7:0] want;
    digits = 16'h0005; dp = '0; blink_mask = '0;
    do_reset();
    for (int c = 0; c < FR; c++) begin
      tick(); e = sb.pop_front(); checks++;
      if (seg_sel !== e.sel || seg_db !== e.db || frame_p !== e.fp) begin
        errors++;
        $display("FAIL lzb cyc=%0d got sel=%b db=%h fp=%b want sel=%b db=%h fp=%b", c, seg_sel, seg_db, frame_p, e.sel, e.db, e.fp);
      end
      if (c == 1 || c == 5 || c == 9 || c == 13) begin
        want = (c == 1) ? 8'h6D : 8'h00;
        checks++;
        if (seg_db !== want) begin errors++; $display("FAIL lzb_digit cyc=%0d got=%h want=%h", c, seg_db, want); end
      end
      if (c == 13) begin
        checks++;
        if (seg_sel !== 4'b0111) begin errors++; $display("FAIL lzb_sel got=%b want=0111", seg_sel); end
      end
      adv();
    end
    digits = 16'h0000;
    do_reset();
    for (int c = 0; c < DW; c++) begin
      tick(); e = sb.pop_front();
      if (c == 1) begin
        checks++;
        if (seg_db !== 8'h3F) begin errors++; $display("FAIL lzb_zero got=%h want=3F", seg_db); end
      end
      adv();
    end
  endtask
`endif

  initial begin
    errors     = 0;
    checks     = 0;
    digits     = '0;
    dp         = '0;
    blink_mask = '0;
    sec_p      = 1'b0;
    pos        = 0;
    ph         = 1'b0;
    rst_n      = 1'b1;
    #1 rst_n   = 1'b0;
    test_reset();
    test_scan();
    test_snapshot();
    test_blink();
    test_invalid_dp();
    test_midframe_reset();
`ifdef SEG_SCAN_LZB_EN
    test_lzb();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
